// File: rtl/rom_bus_adapter.sv
// CPU-side front end for the dual-port boot ROM: one fetch port (ROM port A) and one data port
// (ROM port B). Each port runs its own FSM. Rejected accesses are acknowledged with an error.

module rom_bus_port #(
  parameter logic [31:0] BASE   = 32'h0000_0000,
  parameter int          ROM_AW = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [31:0]       addr,
  output logic              ack,
  output logic [31:0]       data,
  output logic              err,
  output logic              rom_en,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [31:0]       rom_do,
  output logic              wr_reject
);

  localparam int WIN_LO = ROM_AW + 2;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    ACK
  } state_t;

  state_t            state_q, state_d;
  logic              err_q;
  logic [31:0]       data_q;
  logic [ROM_AW-1:0] rom_addr_q;
  logic              in_window;
  logic              accept_read;
  logic              reject;
  logic              unused_addr_bits;

  // Bits [1:0] select a byte within the word; every access is a full word.
  assign unused_addr_bits = ^addr[1:0];
  assign in_window        = (addr[31:WIN_LO] == BASE[31:WIN_LO]);

  // NOTE: every output of this block gets a default first, so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    accept_read = 1'b0;
    reject      = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (in_window && !we) begin
            state_d     = READ;
            accept_read = 1'b1;
          end else begin
            state_d = ACK;
            reject  = 1'b1;
          end
        end
      end
      READ:    state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments, so every register in this block
  // samples values from before the edge, whatever order the statements are written in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      err_q      <= 1'b0;
      data_q     <= '0;
      rom_addr_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept_read) begin
        rom_addr_q <= addr[WIN_LO-1:2];
        err_q      <= 1'b0;
      end
      if (reject) begin
        err_q <= 1'b1;
      end
      // rom_do was updated by the ROM on the falling edge inside the READ cycle.
      if (state_q == READ) begin
        data_q <= rom_do;
      end
    end
  end

  assign ack       = (state_q == ACK);
  assign err       = ack & err_q;
  // A rejected access returns zero without disturbing the last captured word.
  assign data      = err ? 32'h0000_0000 : data_q;
  assign rom_en    = (state_q == READ);
  assign rom_addr  = rom_addr_q;
  assign wr_reject = reject & we;

endmodule

module rom_bus_adapter #(
  parameter logic [31:0] BASE   = 32'h0000_0000,
  parameter int          ROM_AW = 9,
  parameter int          CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [31:0]       i_addr,
  output logic              i_ack,
  output logic [31:0]       i_data,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [31:0]       d_addr,
  output logic              d_ack,
  output logic [31:0]       d_data,
  output logic              d_err,
  output logic              rom_ena,
  output logic [ROM_AW-1:0] rom_addra,
  input  logic [31:0]       rom_doa,
  output logic              rom_enb,
  output logic [ROM_AW-1:0] rom_addrb,
  input  logic [31:0]       rom_dob,
  output logic [CNT_W-1:0]  wr_err_cnt
);

  logic              d_wr_reject;
  logic              i_wr_reject_unused;
  logic [CNT_W-1:0]  cnt_q;

  rom_bus_port #(.BASE(BASE), .ROM_AW(ROM_AW)) u_i_port (
    .clk       (clk),
    .rst       (rst),
    .req       (i_req),
    .we        (1'b0),
    .addr      (i_addr),
    .ack       (i_ack),
    .data      (i_data),
    .err       (i_err),
    .rom_en    (rom_ena),
    .rom_addr  (rom_addra),
    .rom_do    (rom_doa),
    .wr_reject (i_wr_reject_unused)
  );

  rom_bus_port #(.BASE(BASE), .ROM_AW(ROM_AW)) u_d_port (
    .clk       (clk),
    .rst       (rst),
    .req       (d_req),
    .we        (d_we),
    .addr      (d_addr),
    .ack       (d_ack),
    .data      (d_data),
    .err       (d_err),
    .rom_en    (rom_enb),
    .rom_addr  (rom_addrb),
    .rom_do    (rom_dob),
    .wr_reject (d_wr_reject)
  );

  // Saturating count of rejected writes; only the data port can raise a write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (d_wr_reject && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign wr_err_cnt = cnt_q;

endmodule

// File: doc/rom_bus_adapter.md
# rom_bus_adapter

Bus-side front end for the dual-port boot ROM. It accepts instruction-fetch and data-read requests from the CPU memory interface and converts them into enable/address strobes on the ROM's A port (instruction) and B port (data). It captures the negedge-registered ROM outputs and returns them with a one-cycle acknowledge. It also rejects out-of-window accesses and writes, and keeps a saturating count of write attempts.

## Interface
- BASE, 32'h00000000, byte base address of the ROM window; must be aligned to the window size
- ROM_AW, 9, ROM word-address width; window is 2^(ROM_AW+2) bytes
- CNT_W, 8, width of the write-error counter

- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- i_req  in  1  instruction fetch request; sampled only in I-IDLE
- i_addr  in  32  fetch byte address
- i_ack  out  1  one-cycle pulse: fetch complete
- i_data  out  32  fetch data; valid while i_ack=1 and held until the next capture
- i_err  out  1  asserted with i_ack when the address is outside the window
- d_req  in  1  data request; sampled only in D-IDLE
- d_we  in  1  1 = write (not allowed), 0 = read
- d_addr  in  32  data byte address
- d_ack  out  1  one-cycle pulse: data access complete
- d_data  out  32  read data; same hold rule as i_data
- d_err  out  1  asserted with d_ack on an out-of-window access or a write
- rom_ena  out  1  ROM port A enable
- rom_addra  out  ROM_AW  ROM port A word address
- rom_doa  in  32  ROM port A data (ROM registers it on the falling edge of clk)
- rom_enb  out  1  ROM port B enable
- rom_addrb  out  ROM_AW  ROM port B word address
- rom_dob  in  32  ROM port B data
- wr_err_cnt  out  CNT_W  count of rejected writes; saturates at all-ones

## Operation
- There are two independent, identical FSMs: I (port A) and D (port B). They have no shared state except the write counter, which only D updates.
- States: IDLE, READ, ACK.
- IDLE:
  - If no request is present, stay in IDLE.
  - On a request, latch the address and classify it:
    - In window (addr[31:ROM_AW+2] == BASE[31:ROM_AW+2]) and read: go to READ.
    - Out of window, or (D only) d_we=1: go to ACK with err=1 and data forced to 0.
- READ: rom_en=1 and rom_addr = latched addr[ROM_AW+1:2]. At the end of the cycle, capture rom_do into the data register and go to ACK with err=0.
- ACK: ack=1 for exactly one cycle, then return to IDLE. The request input is not sampled in ACK.
  - A requester holding req high issues a new request, which is sampled in the following IDLE cycle.
- Address bits [1:0] are ignored; all accesses are word accesses.
- Write rejection: when D enters ACK due to d_we=1, wr_err_cnt increments by 1 unless it is already all-ones.
  - An out-of-window write counts once.
  - An out-of-window read does not count.
- rom_en is asserted only in READ. rom_addr holds its last value when the enable is low.
- Simultaneous I and D requests, including to the same address, proceed in parallel with no interaction.

## Timing
- Reset values: all FSMs in IDLE; i_ack, d_ack, i_err, d_err, rom_ena, rom_enb = 0; i_data, d_data, rom_addra, rom_addrb, wr_err_cnt = 0.
- Reset asserted mid-access aborts immediately: ack never pulses for the aborted request and data registers return to 0.
- Valid read, request sampled at rising edge N:
  - Enable high during cycle N..N+1.
  - ROM updates at the falling edge within that cycle.
  - Data captured at edge N+1.
  - ack high during cycle N+1..N+2.
  - Latency: 2 cycles from the sampling edge to the ack rise.
- Rejected access: ack high during cycle N..N+1 (latency 1); no ROM enable.
- Throughput: one read every 3 cycles per port; one rejected access every 2 cycles.
- The data register changes only at a READ capture or at reset. err is combinationally tied to the ACK state plus the latched error flag.

## Test plan
- Reset then fetch i_addr=0x00000000: i_ack at cycle +2, i_data=0x080000ED, i_err=0, rom_ena high for exactly one cycle with rom_addra=0.
- Concurrent i_addr=0x3B4 and d_addr=0x3B4 (word 237), same edge: both acks in the same cycle, both data=0x0C000030.
- d_we=1 to 0x10: d_ack at cycle +1, d_err=1, d_data=0, rom_enb never high, wr_err_cnt=1. Repeat 300 times: wr_err_cnt saturates at 255.
- Out-of-window reads i_addr=0x10000000 and d_addr=0x800: ack at +1, err=1, data=0, no ROM enable, wr_err_cnt unchanged.
- i_req held high over addresses 0x4 and 0x8 (changed on each ack): acks every 3 cycles, data 0x00000000 then 0x686F7720. d_addr=0x7 returns the word at 0x4.
- Assert rst during READ: no ack, outputs return to reset values. The first request after release completes normally with latency 2.
